// File: rtl/lockstep_ctrl_if.sv
// Bus bundle between the lockstep sequencer and its surroundings: OBI payload
// types, control/status signals and the delay-stage comparison taps.
interface lockstep_ctrl_if;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    logic            enter_i;
    logic            exit_i;
    logic            clear_fault_i;
    logic [1:0]      core_halted_i;
    obi_req_t        bus_instr_req_i;
    obi_resp_t       bus_instr_resp_i;
    obi_req_t        bus_data_req_i;
    obi_resp_t       bus_data_resp_i;
    obi_req_t  [1:0] cmp_instr_req_i;
    obi_req_t  [1:0] cmp_data_req_i;
    logic            enable_o;
    logic [1:0]      halt_o;
    logic            fault_o;
    logic [7:0]      mismatch_cnt_o;
    logic [2:0]      state_o;

    modport slave (
        input  enter_i, exit_i, clear_fault_i, core_halted_i,
        input  bus_instr_req_i, bus_instr_resp_i, bus_data_req_i, bus_data_resp_i,
        input  cmp_instr_req_i, cmp_data_req_i,
        output enable_o, halt_o, fault_o, mismatch_cnt_o, state_o
    );

    modport master (
        output enter_i, exit_i, clear_fault_i, core_halted_i,
        output bus_instr_req_i, bus_instr_resp_i, bus_data_req_i, bus_data_resp_i,
        output cmp_instr_req_i, cmp_data_req_i,
        input  enable_o, halt_o, fault_o, mismatch_cnt_o, state_o
    );

endinterface

// File: rtl/lockstep_ctrl.sv
// Lockstep entry/exit sequencer: halts and drains both cores, releases them with
// an NCYCLES skew, and compares the delayed request streams while in lockstep.
module lockstep_ctrl #(
    parameter int unsigned NCYCLES         = 2,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned FAULT_THRESHOLD = 1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    lockstep_ctrl_if.slave bus
);

    localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned SYNC_W = $clog2(NCYCLES + 1);
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HALT     = 3'd1,
        SYNC     = 3'd2,
        LOCKSTEP = 3'd3,
        DRAIN    = 3'd4,
        FAULT    = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   instr_out_q, instr_out_d, data_out_q, data_out_d;
    logic [SYNC_W-1:0]  sync_q, sync_d;
    logic [CNT_W-1:0]   mis_q, mis_d;
    logic               enable_q, enable_d, fault_q, fault_d;
    logic [1:0]         halt_q, halt_d;
    logic               drained_c, halted_c, mismatch_c, instr_diff_c, data_diff_c;
    logic               w0_c, w1_c;
    logic               unused;

    function automatic logic [OUT_W-1:0] next_out(input logic [OUT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        logic [OUT_W-1:0] res;
        res = cnt;
        if (inc && !dec && cnt != OUT_W'(MAX_OUTSTANDING)) res = cnt + OUT_W'(1);
        if (dec && !inc && cnt != OUT_W'(0))               res = cnt - OUT_W'(1);
        return res;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            instr_out_q <= '0;
            data_out_q  <= '0;
            sync_q      <= '0;
            mis_q       <= '0;
            enable_q    <= 1'b0;
            halt_q      <= 2'b00;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_out_q <= instr_out_d;
            data_out_q  <= data_out_d;
            sync_q      <= sync_d;
            mis_q       <= mis_d;
            enable_q    <= enable_d;
            halt_q      <= halt_d;
            fault_q     <= fault_d;
        end
    end

    // Next-state, counters and registered-output decode
    always_comb begin
        state_d  = state_q;
        sync_d   = sync_q;
        mis_d    = mis_q;
        enable_d = 1'b0;
        halt_d   = 2'b00;
        fault_d  = 1'b0;

        instr_out_d = next_out(instr_out_q,
                               bus.bus_instr_req_i.req & bus.bus_instr_resp_i.gnt,
                               bus.bus_instr_resp_i.rvalid);
        data_out_d  = next_out(data_out_q,
                               bus.bus_data_req_i.req & bus.bus_data_resp_i.gnt,
                               bus.bus_data_resp_i.rvalid);
        // Look at this cycle's grants/responses so a same-cycle grant blocks exit from HALT
        drained_c = (instr_out_d == OUT_W'(0)) && (data_out_d == OUT_W'(0));
        halted_c  = (bus.core_halted_i == 2'b11);

        instr_diff_c = (bus.cmp_instr_req_i[0].req  != bus.cmp_instr_req_i[1].req) ||
                       (bus.cmp_instr_req_i[0].addr != bus.cmp_instr_req_i[1].addr);
        w0_c = bus.cmp_data_req_i[0].we & bus.cmp_data_req_i[0].req;
        w1_c = bus.cmp_data_req_i[1].we & bus.cmp_data_req_i[1].req;
        data_diff_c  = (bus.cmp_data_req_i[0].req  != bus.cmp_data_req_i[1].req) ||
                       (w0_c != w1_c) ||
                       (bus.cmp_data_req_i[0].addr != bus.cmp_data_req_i[1].addr) ||
                       (bus.cmp_data_req_i[0].be   != bus.cmp_data_req_i[1].be) ||
                       (w0_c && w1_c &&
                        (bus.cmp_data_req_i[0].wdata != bus.cmp_data_req_i[1].wdata));
        mismatch_c = instr_diff_c || data_diff_c;

        case (state_q)
            IDLE: begin
                if (bus.enter_i) begin
                    state_d = HALT;
                    mis_d   = '0;
                end
            end
            HALT: begin
                if (halted_c && drained_c) begin
                    state_d = SYNC;
                    sync_d  = SYNC_W'(NCYCLES);
                end
            end
            SYNC: begin
                sync_d = sync_q - SYNC_W'(1);
                if (sync_q == SYNC_W'(1)) state_d = LOCKSTEP;
            end
            LOCKSTEP: begin
                if (mismatch_c && mis_q != CNT_W'(255)) mis_d = mis_q + CNT_W'(1);
                if (mis_d >= CNT_W'(FAULT_THRESHOLD)) state_d = FAULT;
                else if (bus.exit_i)                  state_d = DRAIN;
            end
            DRAIN: begin
                // sync_q != 0 means the delay pipe is being flushed after the drain
                if (sync_q != SYNC_W'(0)) begin
                    sync_d = sync_q - SYNC_W'(1);
                    if (sync_q == SYNC_W'(1)) state_d = IDLE;
                end else if (halted_c && drained_c) begin
                    if (NCYCLES == 1) state_d = IDLE;
                    else              sync_d  = SYNC_W'(NCYCLES - 1);
                end
            end
            FAULT: begin
                if (bus.clear_fault_i) state_d = DRAIN;
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            HALT:     halt_d = 2'b11;
            SYNC:     begin enable_d = 1'b1; halt_d = 2'b10; end
            LOCKSTEP: enable_d = 1'b1;
            DRAIN:    begin enable_d = 1'b1; halt_d = 2'b11; end
            FAULT:    begin enable_d = 1'b1; halt_d = 2'b11; end
            default:  ;
        endcase
        fault_d = (state_d == FAULT) || (fault_q && state_d != IDLE);
    end

    assign bus.enable_o       = enable_q;
    assign bus.halt_o         = halt_q;
    assign bus.fault_o        = fault_q;
    assign bus.mismatch_cnt_o = mis_q;
    assign bus.state_o        = state_q;

    // Payload fields that play no part in sequencing or comparison
    assign unused = ^{bus.bus_instr_req_i, bus.bus_data_req_i, bus.bus_instr_resp_i,
                      bus.bus_data_resp_i, bus.cmp_instr_req_i, bus.cmp_data_req_i};

endmodule

// File: doc/lockstep_ctrl.md
# lockstep_ctrl

Sequencer for the dual-core lockstep delay stage: `lockstep_ctrl` controls entry into and exit from lockstep mode and checks the two cores against each other while lockstep is active. To enter, it halts both cores, drains outstanding OBI traffic and enables the delay stage. It then releases core 0 NCYCLES cycles before core 1, so that core 0's delayed requests line up with core 1's live requests. While lockstep is active, it compares the two request streams cycle by cycle and raises a sticky fault on divergence. It sits beside the delay stage, driving the delay stage's enable and the cores' halt requests.

## Interface
Parameters:
- NCYCLES, 2, delay depth of the lockstep delay stage; must match it; ≥1
- MAX_OUTSTANDING, 4, outstanding-transaction counter ceiling per bus
- FAULT_THRESHOLD, 1, number of mismatches that trigger FAULT; range 1..255

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- enter_i  in  1  one-cycle request to enter lockstep
- exit_i  in  1  one-cycle request to leave lockstep
- clear_fault_i  in  1  acknowledge fault
- core_halted_i  in  2  per-core halted status
- bus_instr_req_i  in  obi_req_t  shared instruction request (delay-stage output, port 0)
- bus_instr_resp_i  in  obi_resp_t  shared instruction response
- bus_data_req_i  in  obi_req_t  shared data request
- bus_data_resp_i  in  obi_resp_t  shared data response
- cmp_instr_req_i  in  obi_req_t [1:0]  delay-stage instruction request outputs
- cmp_data_req_i  in  obi_req_t [1:0]  delay-stage data request outputs
- enable_o  out  1  drives the delay-stage enable
- halt_o  out  2  per-core halt request
- fault_o  out  1  sticky lockstep fault
- mismatch_cnt_o  out  8  mismatch counter, saturating
- state_o  out  3  current FSM state encoding

## Operation
- Outstanding counters (instruction and data, one each):
  - +1 on req&gnt, −1 on rvalid; both in one cycle leaves the count unchanged.
  - Saturate at MAX_OUTSTANDING and at 0.
  - "Drained" means both counters are 0.
- FSM states, with encodings:
  - IDLE=0:
    - enable_o=0, halt_o=00.
    - enter_i → HALT. exit_i and clear_fault_i are ignored.
  - HALT=1:
    - halt_o=11.
    - core_halted_i==11 && drained → SYNC. Load the sync counter with NCYCLES.
  - SYNC=2:
    - enable_o=1, halt_o=10 (core 0 released).
    - The counter decrements each cycle. On reaching 0 → LOCKSTEP with halt_o=00.
  - LOCKSTEP=3:
    - enable_o=1, halt_o=00, comparator active.
    - exit_i → DRAIN.
    - Mismatch count reaching FAULT_THRESHOLD → FAULT. FAULT has priority over exit_i in the same cycle.
  - DRAIN=4:
    - halt_o=11, enable_o=1.
    - Wait for core_halted_i==11 && drained, then NCYCLES further cycles so the delay pipe empties, then → IDLE.
  - FAULT=5:
    - halt_o=11, enable_o=1, fault_o=1.
    - clear_fault_i → DRAIN. fault_o stays 1 until the FSM reaches IDLE.
- Comparator (active in LOCKSTEP only):
  - Per cycle, compare index 0 against index 1 for instruction: req, addr.
  - Compare for data: req, we&req, addr, be, and wdata only when we&req is 1.
  - Any difference is one mismatch event; at most 1 increment per cycle across both buses.
  - mismatch_cnt_o saturates at 255 and clears on entry to HALT.
- enter_i outside IDLE is ignored.

## Timing
- Reset values: state=IDLE, enable_o=0, halt_o=00, fault_o=0, mismatch_cnt_o=0, all counters 0.
- All outputs are registered; a state change is visible the cycle after its triggering condition.
- Release skew: halt_o[0] falls exactly NCYCLES cycles before halt_o[1].
- Mismatch latency: a difference sampled at cycle t updates mismatch_cnt_o at t+1. With FAULT_THRESHOLD=1, fault_o=1 and state=FAULT at t+1.
- HALT waits indefinitely; there is no timeout.
- Reset mid-operation returns to IDLE immediately, with enable_o=0, regardless of state.

## Test plan
- Entry, NCYCLES=2:
  - Stimulus: enter_i at cycle 0; core_halted_i=11 at cycle 3, bus idle.
  - Required: halt_o=11 at cycle 1; SYNC at cycle 4 with enable_o=1, halt_o=10; LOCKSTEP at cycle 6 with halt_o=00.
- Drain blocking:
  - Stimulus: one instruction req&gnt granted while in HALT, cores halted; rvalid 5 cycles later.
  - Required: SYNC entered only the cycle after rvalid.
- Data mismatch:
  - Stimulus: in LOCKSTEP, cmp_data_req_i[0].wdata=0x1 vs [1].wdata=0x2 with we=1, FAULT_THRESHOLD=1.
  - Required: mismatch_cnt_o=1 and fault_o=1 the next cycle; halt_o=11.
- wdata masking:
  - Stimulus: same wdata difference as above, but we=0, req=1.
  - Required: no mismatch; mismatch_cnt_o stays 0.
- Exit and fault priority:
  - Stimulus A: exit_i in LOCKSTEP with the bus drained.
  - Required A: DRAIN, then IDLE NCYCLES cycles after halted; enable_o then 0.
  - Stimulus B: exit_i and a mismatch in the same cycle.
  - Required B: FAULT.
- Reset mid-SYNC:
  - Stimulus: assert rst_ni=0 during SYNC.
  - Required: enable_o=0, halt_o=00, state_o=0 immediately, asynchronously.
